// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM state
// encoding and default latencies.
package mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU: produces the 64-bit {hi,lo} value to
// be shadowed. MADD accumulate exists only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q_s;
    logic [31:0]        r_s;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b[31] ? (32'd0 - b) : b;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res = {hi, lo};
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   if (b != 32'd0) res = {r_s, q_s};
            OP_DIVU:  if (b != 32'd0) res = {a % b, a / b};
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi, lo} + prod_s;
`endif
            default:  res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_scheduler.sv
// MDU sequencer: busy FSM with fixed latency counter, shadow and HI/LO
// registers, and the D-stage stall request. Optional MADD via MDU_MADD_EN.
module mdu_scheduler
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        dbg_state
);

    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] sh_q, sh_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] calc_res;
    logic        is_mul;
    logic        is_div;

    mdu_calc u_calc (
        .op  (op),
        .a   (A),
        .b   (B),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (calc_res)
    );

`ifdef MDU_MADD_EN
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
`else
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        sh_d    = calc_res;
                        cnt_d   = 5'(MULT_LAT);
                        state_d = ST_RUN;
                    end else if (is_div) begin
                        sh_d    = calc_res;
                        cnt_d   = 5'(DIV_LAT);
                        state_d = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = A;
                    end else if (op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                // start is ignored here; the hazard unit keeps it from happening
                if (cnt_q == 5'd1) begin
                    {hi_d, lo_d} = sh_q;
                    cnt_d        = 5'd0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            sh_q    <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign stall_md  = md_use_D & (start | busy);
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler: latency, arithmetic results, MTHI/MTLO,
// stall behaviour, asynchronous reset and the MDU_MADD_EN option.
module tb_mdu_scheduler;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        dbg_state;

    int checks   = 0;
    int failures = 0;
    int nbusy;

    mdu_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .md_use_D  (md_use_D),
        .busy      (busy),
        .stall_md  (stall_md),
        .HI        (HI),
        .LO        (LO),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command for a single cycle, then count the busy cycles (bounded).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        op    = OP_NONE;
        n     = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && busy === 1'b1 && start === 1'b1) begin
            failures++;
            $error("FAIL start_during_run observed=1 expected=0");
        end
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        op       = OP_NONE;
        A        = 32'd0;
        B        = 32'd0;
        md_use_D = 1'b0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_state", {63'd0, dbg_state}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        md_use_D = 1'b1;
        #1;
        check("reset_stall", {63'd0, stall_md}, 64'd0);
        md_use_D = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // MULT -2 * 3
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, nbusy);
        check("mult_lat", 64'(nbusy), 64'd5);
        check("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);

        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, nbusy);
        check("multu_lat", 64'(nbusy), 64'd5);
        check("multu_hilo", {HI, LO}, 64'h00000002_FFFFFFFA);

        // DIV -7 / 2: quotient -3, remainder -1
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, nbusy);
        check("div_lat", 64'(nbusy), 64'd10);
        check("div_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

        issue(OP_DIVU, 32'd7, 32'd0, nbusy);
        check("divu0_lat", 64'(nbusy), 64'd10);
        check("divu0_hold", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nbusy);
        check("div_ovf", {HI, LO}, 64'h00000000_80000000);

        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, nbusy);
        check("div_pos_neg", {HI, LO}, 64'h00000001_FFFFFFFD);

        issue(OP_DIVU, 32'd100, 32'd7, nbusy);
        check("divu_hilo", {HI, LO}, 64'h00000002_0000000E);

        // MTLO with an MDU instruction in D: one-cycle stall only
        start    = 1'b1;
        op       = OP_MTLO;
        A        = 32'h1234;
        md_use_D = 1'b1;
        #1;
        check("mtlo_stall", {63'd0, stall_md}, 64'd1);
        tick();
        start = 1'b0;
        op    = OP_NONE;
        #1;
        check("mtlo_stall_clr", {63'd0, stall_md}, 64'd0);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mtlo_lo", {HI, LO}, 64'h00000002_00001234);
        md_use_D = 1'b0;

        start = 1'b1;
        op    = OP_MTHI;
        A     = 32'hABCD0000;
        tick();
        start = 1'b0;
        op    = OP_NONE;
        check("mthi_hi", {HI, LO}, 64'hABCD0000_00001234);
        check("mthi_busy", {63'd0, busy}, 64'd0);

        // start with op NONE is a no-op
        issue(OP_NONE, 32'd5, 32'd5, nbusy);
        check("none_lat", 64'(nbusy), 64'd0);
        check("none_hilo", {HI, LO}, 64'hABCD0000_00001234);

        // MULT then mflo in D: stall cycles 0..5, result readable in cycle 6
        start    = 1'b1;
        op       = OP_MULT;
        A        = 32'd7;
        B        = 32'd6;
        md_use_D = 1'b1;
        #1;
        check("mflo_stall_c0", {63'd0, stall_md}, 64'd1);
        tick();
        start = 1'b0;
        op    = OP_NONE;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("mflo_stall_c%0d", c), {62'd0, busy, stall_md}, 64'd3);
            check($sformatf("mflo_lo_old_c%0d", c), {32'd0, LO}, 64'h1234);
            tick();
        end
        check("mflo_stall_c6", {62'd0, busy, stall_md}, 64'd0);
        check("mflo_result", {HI, LO}, 64'd42);
        md_use_D = 1'b0;
        issue(OP_MULTU, 32'd2, 32'd2, nbusy);
        check("b2b_lat", 64'(nbusy), 64'd5);
        check("b2b_hilo", {HI, LO}, 64'd4);

        // Asynchronous reset during cycle 3 of a DIV
        start = 1'b1;
        op    = OP_DIV;
        A     = 32'd100;
        B     = 32'd3;
        tick();
        start = 1'b0;
        op    = OP_NONE;
        tick();
        tick();
        check("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {62'd0, busy, dbg_state}, 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        issue(OP_MULT, 32'd2, 32'd3, nbusy);
        check("post_rst_lat", 64'(nbusy), 64'd5);
        check("post_rst_hilo", {HI, LO}, 64'd6);

        // MADD onto HI:LO = 0:0xFFFFFFFF
        start = 1'b1;
        op    = OP_MTLO;
        A     = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        op    = OP_NONE;
        issue(OP_MADD, 32'd1, 32'd1, nbusy);
`ifdef MDU_MADD_EN
        check("madd_lat", 64'(nbusy), 64'd5);
        check("madd_hilo", {HI, LO}, 64'h00000001_00000000);
`else
        check("madd_lat", 64'(nbusy), 64'd0);
        check("madd_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
